// File: rtl/data_break_arb_pkg.sv
// Shared definitions for the data-break arbiter: state codes, break modes and field limit.
package data_break_arb_pkg;

    localparam int AW = 15;
    localparam int DW = 12;
    localparam int FW = 3;

    // Highest populated memory field; anything above reads as 0 and is never written.
    localparam logic [FW-1:0] MAX_FIELD_DEF = 3'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        B_RD  = 3'd1,
        B_RDW = 3'd2,
        B_WR  = 3'd3,
        B_ACK = 3'd4
    } brk_state_t;

    typedef enum logic [1:0] {
        BRK_RD  = 2'b00,
        BRK_WR  = 2'b01,
        BRK_INC = 2'b10,
        BRK_ADD = 2'b11
    } brk_mode_t;

    function automatic logic field_ok(input logic [FW-1:0] field, input logic [FW-1:0] max_field);
        return field <= max_field;
    endfunction

endpackage

// File: rtl/data_break_arb_brk_pick.sv
// Combinational break-channel selector: rotating priority starting at i_ptr,
// or fixed priority with channel 0 highest.
module brk_pick #(
    parameter int NCH         = 2,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int PW          = 1
) (
    input  logic [NCH-1:0] i_rq,
    input  logic [PW-1:0]  i_ptr,
    output logic [NCH-1:0] o_gnt,
    output logic [PW-1:0]  o_idx
);

    logic w_found;
    int   w_c;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int i = 0; i < NCH; i++) begin
            w_c = ROUND_ROBIN ? (int'(i_ptr) + i) % NCH : i;
            for (int j = 0; j < NCH; j++) begin
                if (!w_found && (j == w_c) && i_rq[j]) begin
                    w_found  = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_idx    = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/data_break_arb.sv
// Shares the core RAM port between the CPU and data-break channels; one break
// cycle (read / write / increment / add-to-memory) per grant, CPU stalled throughout.
//   state | meaning
//   IDLE  | CPU owns the RAM port; grant at a break point
//   B_RD  | break address presented, read issued
//   B_RDW | read data back; old word and modified word captured
//   B_WR  | modified word written (unless field is unpopulated)
//   B_ACK | one-cycle done pulse to the granted channel
module data_break_arb
    import data_break_arb_pkg::*;
#(
    parameter int             NCH         = 2,
    parameter bit             ROUND_ROBIN = 1'b1,
    parameter logic [FW-1:0]  MAX_FIELD   = MAX_FIELD_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [AW-1:0]     i_cpu_addr,
    input  logic [DW-1:0]     i_cpu_din,
    input  logic              i_cpu_we,
    input  logic              i_cpu_brk_ok,
    output logic              o_cpu_stall,
    input  logic [NCH-1:0]    i_brk_rq,
    input  logic [AW*NCH-1:0] i_brk_addr,
    input  logic [2*NCH-1:0]  i_brk_mode,
    input  logic [DW*NCH-1:0] i_brk_wdata,
    output logic [NCH-1:0]    o_brk_ack,
    output logic [DW-1:0]     o_brk_rdata,
    output logic              o_brk_ovf,
    output logic [AW-1:0]     o_mem_addr,
    output logic [DW-1:0]     o_mem_din,
    output logic              o_mem_we,
    input  logic [DW-1:0]     i_mem_dout
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    brk_state_t     r_state;
    brk_state_t     w_state_nxt;
    logic [AW-1:0]  r_addr;
    brk_mode_t      r_mode;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_wd;
    logic [DW-1:0]  r_rdata;
    logic           r_ovf;
    logic [NCH-1:0] r_gnt;
    logic [PW-1:0]  r_ptr;

    logic [NCH-1:0] w_gnt;
    logic [PW-1:0]  w_idx;
    logic           w_start;
    logic [AW-1:0]  w_sel_addr;
    logic [1:0]     w_sel_mode;
    logic [DW-1:0]  w_sel_wdata;
    logic           w_fld_ok;
    logic [DW-1:0]  w_rd;
    logic [DW:0]    w_mod;

    brk_pick #(
        .NCH         (NCH),
        .ROUND_ROBIN (ROUND_ROBIN),
        .PW          (PW)
    ) u_pick (
        .i_rq  (i_brk_rq),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_start = (r_state == IDLE) && i_cpu_brk_ok && (|i_brk_rq);

    always_comb begin
        w_sel_addr  = '0;
        w_sel_mode  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = i_brk_addr[i*AW +: AW];
                w_sel_mode  = i_brk_mode[i*2 +: 2];
                w_sel_wdata = i_brk_wdata[i*DW +: DW];
            end
        end
    end

    assign w_fld_ok = field_ok(r_addr[AW-1 -: FW], MAX_FIELD);
    assign w_rd     = w_fld_ok ? i_mem_dout : '0;

    // Bit DW of w_mod is the carry; it is zero by construction for read and write.
    always_comb begin
        w_mod = '0;
        case (r_mode)
            BRK_RD:  w_mod = {1'b0, w_rd};
            BRK_WR:  w_mod = {1'b0, r_wdata};
            BRK_INC: w_mod = {1'b0, w_rd} + {{DW{1'b0}}, 1'b1};
            BRK_ADD: w_mod = {1'b0, w_rd} + {1'b0, r_wdata};
            default: w_mod = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_mode  <= BRK_RD;
            r_wdata <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_rdata <= '0;
            r_wd    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= w_sel_addr;
                r_mode  <= brk_mode_t'(w_sel_mode);
                r_wdata <= w_sel_wdata;
                r_gnt   <= w_gnt;
                r_ptr   <= PW'((int'(w_idx) + 1) % NCH);
            end
            if (r_state == B_RDW) begin
                r_rdata <= w_rd;
                r_wd    <= w_mod[DW-1:0];
                r_ovf   <= w_mod[DW];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = B_RD;
            B_RD:    w_state_nxt = B_RDW;
            B_RDW:   w_state_nxt = (r_mode == BRK_RD) ? B_ACK : B_WR;
            B_WR:    w_state_nxt = B_ACK;
            B_ACK:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Port ownership decodes from state so an async reset returns it to the CPU at once.
    always_comb begin
        o_mem_addr  = i_cpu_addr;
        o_mem_din   = i_cpu_din;
        o_mem_we    = i_cpu_we;
        o_cpu_stall = 1'b0;
        o_brk_ack   = '0;
        case (r_state)
            IDLE: begin
            end
            B_RD, B_RDW: begin
                o_mem_addr  = r_addr;
                o_mem_din   = r_wd;
                o_mem_we    = 1'b0;
                o_cpu_stall = 1'b1;
            end
            B_WR: begin
                o_mem_addr  = r_addr;
                o_mem_din   = r_wd;
                o_mem_we    = w_fld_ok;
                o_cpu_stall = 1'b1;
            end
            B_ACK: begin
                o_mem_addr  = r_addr;
                o_mem_din   = r_wd;
                o_mem_we    = 1'b0;
                o_cpu_stall = 1'b1;
                o_brk_ack   = r_gnt;
            end
            default: begin
            end
        endcase
    end

    assign o_brk_rdata = r_rdata;
    assign o_brk_ovf   = r_ovf;

endmodule

// File: tb/tb_data_break_arb.sv
// Directed bench: two arbiters (round-robin / full memory, and fixed / field-0-only)
// run in lockstep on shared stimulus, each with its own synchronous RAM model.
module tb_data_break_arb;
    import data_break_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_din;
    logic        cpu_we;
    logic        cpu_brk_ok;
    logic [1:0]  brk_rq;
    logic [29:0] brk_addr;
    logic [3:0]  brk_mode;
    logic [23:0] brk_wdata;

    logic        stall_a, stall_b;
    logic [1:0]  ack_a, ack_b;
    logic [11:0] rdata_a, rdata_b;
    logic        ovf_a, ovf_b;
    logic [14:0] maddr_a, maddr_b;
    logic [11:0] mdin_a, mdin_b;
    logic        mwe_a, mwe_b;
    logic [11:0] mdout_a, mdout_b;

    logic [11:0] ram_a [0:32767];
    logic [11:0] ram_b [0:32767];
    int          wcnt_a = 0;
    int          wcnt_b = 0;
    logic        pl_en;
    logic [14:0] pl_addr;
    logic [11:0] pl_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    data_break_arb #(.NCH(2), .ROUND_ROBIN(1'b1), .MAX_FIELD(3'd3)) dut_a (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din), .i_cpu_we(cpu_we),
        .i_cpu_brk_ok(cpu_brk_ok), .o_cpu_stall(stall_a),
        .i_brk_rq(brk_rq), .i_brk_addr(brk_addr), .i_brk_mode(brk_mode),
        .i_brk_wdata(brk_wdata), .o_brk_ack(ack_a), .o_brk_rdata(rdata_a),
        .o_brk_ovf(ovf_a), .o_mem_addr(maddr_a), .o_mem_din(mdin_a),
        .o_mem_we(mwe_a), .i_mem_dout(mdout_a)
    );

    data_break_arb #(.NCH(2), .ROUND_ROBIN(1'b0), .MAX_FIELD(3'd0)) dut_b (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din), .i_cpu_we(cpu_we),
        .i_cpu_brk_ok(cpu_brk_ok), .o_cpu_stall(stall_b),
        .i_brk_rq(brk_rq), .i_brk_addr(brk_addr), .i_brk_mode(brk_mode),
        .i_brk_wdata(brk_wdata), .o_brk_ack(ack_b), .o_brk_rdata(rdata_b),
        .o_brk_ovf(ovf_b), .o_mem_addr(maddr_b), .o_mem_din(mdin_b),
        .o_mem_we(mwe_b), .i_mem_dout(mdout_b)
    );

    always @(posedge clk) begin
        if (pl_en) ram_a[pl_addr] <= pl_data;
        else if (mwe_a) begin
            ram_a[maddr_a] <= mdin_a;
            wcnt_a <= wcnt_a + 1;
        end
        mdout_a <= ram_a[maddr_a];
    end

    always @(posedge clk) begin
        if (pl_en) ram_b[pl_addr] <= pl_data;
        else if (mwe_b) begin
            ram_b[maddr_b] <= mdin_b;
            wcnt_b <= wcnt_b + 1;
        end
        mdout_b <= ram_b[maddr_b];
    end

    typedef struct {
        int          ch;
        logic [14:0] addr;
        logic [1:0]  mode;
        logic [11:0] wdata;
        logic [11:0] init;
        logic [11:0] rd_a;
        logic        ovf_a;
        logic [11:0] ram_a;
        logic        we_a;
        logic [11:0] rd_b;
        logic        ovf_b;
        logic [11:0] ram_b;
        logic        we_b;
        int          lat;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o", name, act, exp);
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    int            lat;
    int            wa0, wb0;
    logic [1:0]    qa[$];
    logic [1:0]    qb[$];
    int            b_ch1;
    logic          ack_seen;

    initial begin
        reset      = 1'b1;
        cpu_addr   = '0;
        cpu_din    = '0;
        cpu_we     = 1'b0;
        cpu_brk_ok = 1'b0;
        brk_rq     = '0;
        brk_addr   = '0;
        brk_mode   = '0;
        brk_wdata  = '0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;

        //           ch addr       mode   wdata     init      rd_a      oa    ram_a     wa    rd_b      ob    ram_b     wb    lat
        vt[0] = '{0, 15'o00200, 2'b00, 12'o0000, 12'o1234, 12'o1234, 1'b0, 12'o1234, 1'b0, 12'o1234, 1'b0, 12'o1234, 1'b0, 3};
        vt[1] = '{1, 15'o00020, 2'b10, 12'o0000, 12'o7777, 12'o7777, 1'b1, 12'o0000, 1'b1, 12'o7777, 1'b1, 12'o0000, 1'b1, 4};
        vt[2] = '{0, 15'o10300, 2'b11, 12'o0011, 12'o7770, 12'o7770, 1'b1, 12'o0001, 1'b1, 12'o0000, 1'b0, 12'o7770, 1'b0, 4};
        vt[3] = '{1, 15'o00500, 2'b01, 12'o4567, 12'o0123, 12'o0123, 1'b0, 12'o4567, 1'b1, 12'o0123, 1'b0, 12'o4567, 1'b1, 4};
        vt[4] = '{0, 15'o00600, 2'b10, 12'o0000, 12'o0017, 12'o0017, 1'b0, 12'o0020, 1'b1, 12'o0017, 1'b0, 12'o0020, 1'b1, 4};
        vt[5] = '{1, 15'o00700, 2'b11, 12'o2000, 12'o1000, 12'o1000, 1'b0, 12'o3000, 1'b1, 12'o1000, 1'b0, 12'o3000, 1'b1, 4};
        vt[6] = '{0, 15'o20001, 2'b00, 12'o0000, 12'o5555, 12'o5555, 1'b0, 12'o5555, 1'b0, 12'o0000, 1'b0, 12'o5555, 1'b0, 3};
        vt[7] = '{1, 15'o30002, 2'b10, 12'o0000, 12'o7777, 12'o7777, 1'b1, 12'o0000, 1'b1, 12'o0000, 1'b0, 12'o7777, 1'b0, 4};
        vt[8] = '{0, 15'o40003, 2'b01, 12'o3333, 12'o2222, 12'o0000, 1'b0, 12'o2222, 1'b0, 12'o0000, 1'b0, 12'o2222, 1'b0, 4};

        #2;
        chk("rst_stall", stall_a, 1'b0);
        chk("rst_ack", ack_a, 2'b00);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_rdata", rdata_a, 12'o0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            preload(vt[v].addr, vt[v].init);
            brk_addr[vt[v].ch*15 +: 15]  = vt[v].addr;
            brk_mode[vt[v].ch*2 +: 2]    = vt[v].mode;
            brk_wdata[vt[v].ch*12 +: 12] = vt[v].wdata;
            brk_rq     = 2'b01 << vt[v].ch;
            cpu_brk_ok = 1'b1;
            wa0 = wcnt_a;
            wb0 = wcnt_b;
            @(posedge clk);
            lat = 0;
            for (int k = 1; k <= 10 && lat == 0; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    brk_rq = '0;
                    chk($sformatf("v%0d_stall_a", v), stall_a, 1'b1);
                    chk($sformatf("v%0d_stall_b", v), stall_b, 1'b1);
                end
                if (ack_a != 2'b00) lat = k;
            end
            chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
            chk($sformatf("v%0d_ack_a", v), ack_a, 32'(1) << vt[v].ch);
            chk($sformatf("v%0d_ack_b", v), ack_b, 32'(1) << vt[v].ch);
            chk($sformatf("v%0d_rdata_a", v), rdata_a, vt[v].rd_a);
            chk($sformatf("v%0d_ovf_a", v), ovf_a, vt[v].ovf_a);
            chk($sformatf("v%0d_ram_a", v), ram_a[vt[v].addr], vt[v].ram_a);
            chk($sformatf("v%0d_writes_a", v), wcnt_a - wa0, 32'(vt[v].we_a));
            chk($sformatf("v%0d_rdata_b", v), rdata_b, vt[v].rd_b);
            chk($sformatf("v%0d_ovf_b", v), ovf_b, vt[v].ovf_b);
            chk($sformatf("v%0d_ram_b", v), ram_b[vt[v].addr], vt[v].ram_b);
            chk($sformatf("v%0d_writes_b", v), wcnt_b - wb0, 32'(vt[v].we_b));
            @(negedge clk);
            chk($sformatf("v%0d_stall_clr", v), stall_a, 1'b0);
            chk($sformatf("v%0d_ack_clr", v), ack_a, 2'b00);
        end

        // Contention from a fresh reset: both channels request continuously.
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        brk_addr   = {15'o00020, 15'o00200};
        brk_mode   = 4'b0000;
        brk_rq     = 2'b11;
        cpu_brk_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_a != 2'b00) qa.push_back(ack_a);
            if (ack_b != 2'b00) qb.push_back(ack_b);
        end
        brk_rq = '0;
        repeat (6) @(negedge clk);
        chk("t4_count_a", 32'(qa.size() >= 4), 1);
        chk("t4_count_b", 32'(qb.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_rr_ack%0d", i), (i < qa.size()) ? qa[i] : 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t4_fix_ack%0d", i), (i < qb.size()) ? qb[i] : 2'b00, 2'b01);
        end
        b_ch1 = 0;
        foreach (qb[i]) if (qb[i][1]) b_ch1++;
        chk("t4_fix_no_ch1", b_ch1, 0);

        // Gating: request pending but CPU not at a break point.
        brk_addr[14:0] = 15'o00200;
        brk_mode       = 4'b0000;
        brk_rq         = 2'b01;
        cpu_brk_ok     = 1'b0;
        cpu_addr       = 15'o01234;
        cpu_din        = 12'o4321;
        cpu_we         = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t5_nostall%0d", k), stall_a | stall_b, 1'b0);
            chk($sformatf("t5_pass%0d", k),
                32'((maddr_a == cpu_addr) && (mdin_a == cpu_din) && (mwe_a == cpu_we)), 1);
        end
        cpu_brk_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_grant_stall", stall_a, 1'b1);
        chk("t5_grant_we", mwe_a, 1'b0);
        chk("t5_grant_addr", maddr_a, 15'o00200);
        brk_rq = '0;
        cpu_we = 1'b0;
        ack_seen = 1'b0;
        for (int k = 0; k < 10 && !ack_seen; k++) begin
            @(negedge clk);
            if (ack_a == 2'b01) ack_seen = 1'b1;
        end
        chk("t5_ack", ack_seen, 1'b1);
        @(negedge clk);

        // Reset while a write break sits in B_RDW.
        preload(15'o00400, 12'o1111);
        cpu_addr        = 15'o05555;
        brk_addr[14:0]  = 15'o00400;
        brk_mode[1:0]   = 2'b01;
        brk_wdata[11:0] = 12'o7070;
        brk_rq          = 2'b01;
        cpu_brk_ok      = 1'b1;
        wa0 = wcnt_a;
        @(posedge clk);
        @(negedge clk);
        brk_rq = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_stall", stall_a, 1'b0);
        chk("t6_ack", ack_a, 2'b00);
        chk("t6_we", mwe_a, 1'b0);
        chk("t6_pass_addr", maddr_a, 15'o05555);
        ack_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_a != 2'b00) ack_seen = 1'b1;
        end
        chk("t6_no_ack", ack_seen, 1'b0);
        chk("t6_ram", ram_a[15'o00400], 12'o1111);
        chk("t6_writes", wcnt_a - wa0, 0);
        chk("t6_idle_stall", stall_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
